// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register RAW/WAW hazard scoreboard; optional SCOREBOARD_WB_BYPASS_EN
module reg_scoreboard #(
  parameter int REG_SEL_W   = 5,
  parameter int REG_NUM     = 2 ** REG_SEL_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iIssueValid,
  input  logic [REG_SEL_W-1:0]   iRs1Addr,
  input  logic                   iRs1Dv,
  input  logic [REG_SEL_W-1:0]   iRs2Addr,
  input  logic                   iRs2Dv,
  input  logic [REG_SEL_W-1:0]   iRdAddr,
  input  logic                   iRdDv,
  output logic                   oIssueReady,
  input  logic                   iWb0En,
  input  logic [REG_SEL_W-1:0]   iWb0Addr,
  input  logic                   iWb1En,
  input  logic [REG_SEL_W-1:0]   iWb1Addr,
  output logic [REG_NUM-1:0]     oBusy,
  output logic [REG_SEL_W:0]     oPendingCnt,
  output logic [STALL_CNT_W-1:0] oStallCnt,
  output logic                   oWbErr
);

  logic [REG_NUM-1:0]     busy_q, busy_d;
  logic [REG_SEL_W:0]     pending_q, pending_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   wb_err_q, wb_err_d;

  logic [REG_NUM-1:0] wb_clr;
  logic [REG_NUM-1:0] eff_busy;
  logic [REG_NUM-1:0] set_vec;
  logic               hazard;
  logic               issue_ready;
  logic               fire;

  // Writeback clear mask and the busy view used for hazard detection
  always_comb begin
    wb_clr = '0;
    if (iWb0En) wb_clr = wb_clr | (REG_NUM'(1) << iWb0Addr);
    if (iWb1En) wb_clr = wb_clr | (REG_NUM'(1) << iWb1Addr);
`ifdef SCOREBOARD_WB_BYPASS_EN
    // Operands retiring this cycle are forwarded by the register file bypass
    eff_busy = busy_q & ~wb_clr;
`else
    eff_busy = busy_q;
`endif
  end

  // Hazard check; x0 never hazards because busy[0] is held at 0
  always_comb begin
    hazard = (iRs1Dv & eff_busy[iRs1Addr]) |
             (iRs2Dv & eff_busy[iRs2Addr]) |
             (iRdDv  & eff_busy[iRdAddr]);
    issue_ready = iRst | ~hazard;
    fire        = iIssueValid & issue_ready;
  end

  // Next busy vector (set beats clear), popcount, stall counter and error flag
  always_comb begin
    set_vec = '0;
    if (fire && iRdDv && (iRdAddr != '0)) set_vec = REG_NUM'(1) << iRdAddr;
    busy_d    = (busy_q & ~wb_clr) | set_vec;
    busy_d[0] = 1'b0;

    pending_d = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      pending_d = pending_d + {{REG_SEL_W{1'b0}}, busy_d[i]};
    end

    stall_d = stall_q;
    if (iIssueValid && !issue_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end

    wb_err_d = wb_err_q;
    if (iWb0En && (iWb0Addr != '0) && !busy_q[iWb0Addr]) wb_err_d = 1'b1;
    if (iWb1En && (iWb1Addr != '0) && !busy_q[iWb1Addr]) wb_err_d = 1'b1;
  end

  // State registers with synchronous reset
  always_ff @(posedge iClk) begin
    if (iRst) begin
      busy_q    <= '0;
      pending_q <= '0;
      stall_q   <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
      stall_q   <= stall_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign oIssueReady = issue_ready;
  assign oBusy       = busy_q;
  assign oPendingCnt = pending_q;
  assign oStallCnt   = stall_q;
  assign oWbErr      = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - scoreboard testbench for reg_scoreboard
module tb_reg_scoreboard;

  localparam int SW  = 5;
  localparam int RN  = 32;
  localparam int SCW = 4;
  localparam int SAT = 15;

  localparam int K_RDY  = 0;
  localparam int K_BUSY = 1;
  localparam int K_PEND = 2;
  localparam int K_STL  = 3;
  localparam int K_ERR  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           iv;
  logic [SW-1:0]  rs1, rs2, rd;
  logic           rs1dv, rs2dv, rddv;
  logic           rdy;
  logic           wb0en, wb1en;
  logic [SW-1:0]  wb0a, wb1a;
  logic [RN-1:0]  busy;
  logic [SW:0]    pend;
  logic [SCW-1:0] stl;
  logic           werr;

  reg_scoreboard #(.REG_SEL_W(SW), .REG_NUM(RN), .STALL_CNT_W(SCW)) dut (
    .iClk(clk), .iRst(rst), .iIssueValid(iv),
    .iRs1Addr(rs1), .iRs1Dv(rs1dv), .iRs2Addr(rs2), .iRs2Dv(rs2dv),
    .iRdAddr(rd), .iRdDv(rddv), .oIssueReady(rdy),
    .iWb0En(wb0en), .iWb0Addr(wb0a), .iWb1En(wb1en), .iWb1Addr(wb1a),
    .oBusy(busy), .oPendingCnt(pend), .oStallCnt(stl), .oWbErr(werr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int stall_exp = 0;

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_RDY:   return {31'b0, rdy};
      K_BUSY:  return busy;
      K_PEND:  return {26'b0, pend};
      K_STL:   return {28'b0, stl};
      default: return {31'b0, werr};
    endcase
  endfunction

  task automatic push(input int c, input int kind, input logic [31:0] val, input string name);
    exp_t e;
    int   pos;
    e.cyc = c; e.kind = kind; e.val = val; e.name = name;
    pos = q.size();
    while (pos > 0 && q[pos-1].cyc > c) pos--;
    q.insert(pos, e);
  endtask

  task automatic expect_now(input int kind, input logic [31:0] val, input string name);
    push(cyc, kind, val, name);
  endtask

  task automatic expect_next(input int kind, input logic [31:0] val, input string name);
    push(cyc + 1, kind, val, name);
  endtask

  // Monitor: compares every expectation due in the current cycle, mid-cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t        e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.kind);
      checks++;
      if (a !== e.val) begin
        errors++;
        $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", e.name, cyc, a, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iv = 0; rs1 = 0; rs2 = 0; rd = 0; rs1dv = 0; rs2dv = 0; rddv = 0;
    wb0en = 0; wb1en = 0; wb0a = 0; wb1a = 0;
  endtask

  task automatic issue_rd(input int r);
    idle();
    iv = 1; rd = SW'(r); rddv = 1;
  endtask

  initial begin
    idle();
    rst = 1;
    step();
    step();
    expect_now(K_RDY, 1, "ready_in_reset");
    rst = 0;
    step();
    expect_now(K_BUSY, 0, "reset_busy");
    expect_now(K_PEND, 0, "reset_pending");
    expect_now(K_STL, 0, "reset_stall");
    expect_now(K_ERR, 0, "reset_wberr");
    expect_now(K_RDY, 1, "reset_ready");

    issue_rd(5);
    expect_now(K_RDY, 1, "issue5_ready");
    expect_next(K_BUSY, 32'h20, "issue5_busy");
    expect_next(K_PEND, 1, "issue5_pending");
    expect_next(K_ERR, 0, "issue5_wberr");
    step();

    idle(); iv = 1; rs1 = 5; rs1dv = 1;
    expect_now(K_RDY, 0, "raw5_stall_a");
    stall_exp++;
    expect_next(K_STL, stall_exp, "raw5_cnt_a");
    step();
    expect_now(K_RDY, 0, "raw5_stall_b");
    stall_exp++;
    expect_next(K_STL, stall_exp, "raw5_cnt_b");
    step();
    wb0en = 1; wb0a = 5;
`ifdef SCOREBOARD_WB_BYPASS_EN
    expect_now(K_RDY, 1, "raw5_wb_ready");
`else
    expect_now(K_RDY, 0, "raw5_wb_ready");
    stall_exp++;
`endif
    expect_next(K_STL, stall_exp, "raw5_wb_cnt");
    expect_next(K_BUSY, 0, "raw5_wb_busy");
    expect_next(K_ERR, 0, "raw5_wb_err");
    step();
    wb0en = 0;
    expect_now(K_RDY, 1, "raw5_after_ready");
    expect_next(K_STL, stall_exp, "raw5_after_cnt");
    step();

    idle(); iv = 1; rd = 0; rddv = 1; rs1 = 0; rs1dv = 1; rs2 = 0; rs2dv = 1;
    expect_now(K_RDY, 1, "x0_ready");
    expect_next(K_BUSY, 0, "x0_busy");
    expect_next(K_PEND, 0, "x0_pending");
    step();
    idle(); wb1en = 1; wb1a = 0;
    expect_next(K_ERR, 0, "x0_wb_err");
    step();

    issue_rd(3);
    step();
    issue_rd(7);
    expect_next(K_BUSY, 32'h88, "busy_3_7");
    expect_next(K_PEND, 2, "pending_3_7");
    step();
    idle(); wb0en = 1; wb0a = 3; wb1en = 1; wb1a = 7;
    expect_next(K_BUSY, 0, "dual_wb_busy");
    expect_next(K_PEND, 0, "dual_wb_pending");
    expect_next(K_ERR, 0, "dual_wb_err");
    step();
    issue_rd(3);
    step();
    idle(); wb0en = 1; wb0a = 3; wb1en = 1; wb1a = 3;
    expect_next(K_BUSY, 0, "same_addr_busy");
    expect_next(K_ERR, 0, "same_addr_err");
    step();

    issue_rd(9);
    expect_next(K_BUSY, 32'h200, "busy9");
    step();
    issue_rd(9); wb0en = 1; wb0a = 9;
`ifdef SCOREBOARD_WB_BYPASS_EN
    expect_now(K_RDY, 1, "waw9_ready");
    expect_next(K_BUSY, 32'h200, "set_wins_busy");
    expect_next(K_PEND, 1, "set_wins_pending");
    expect_next(K_STL, stall_exp, "waw9_cnt");
    step();
    idle(); wb0en = 1; wb0a = 9;
    expect_next(K_BUSY, 0, "clear9_busy");
    step();
`else
    expect_now(K_RDY, 0, "waw9_ready");
    stall_exp++;
    expect_next(K_STL, stall_exp, "waw9_cnt");
    expect_next(K_BUSY, 0, "waw9_busy");
    step();
`endif
    expect_now(K_ERR, 0, "pre_sat_err");

    issue_rd(4);
    expect_next(K_BUSY, 32'h10, "busy4");
    step();
    for (int i = 0; i < 20; i++) begin
      idle(); iv = 1; rs2 = 4; rs2dv = 1;
      expect_now(K_RDY, 0, "sat_stall_ready");
      stall_exp = (stall_exp < SAT) ? stall_exp + 1 : SAT;
      expect_next(K_STL, stall_exp, "sat_cnt");
      step();
    end
    idle();
    expect_now(K_STL, SAT, "sat_value");
    expect_next(K_STL, SAT, "sat_hold");
    step();

    wb0en = 1; wb0a = 12;
    expect_next(K_ERR, 1, "spurious_err");
    expect_next(K_BUSY, 32'h10, "spurious_noop_busy");
    step();
    idle(); wb0en = 1; wb0a = 4;
    expect_next(K_ERR, 1, "err_sticky");
    expect_next(K_BUSY, 0, "clear4_busy");
    step();

    issue_rd(6);
    step();
    idle(); iv = 1; rs1 = 6; rs1dv = 1; rst = 1;
    expect_now(K_RDY, 1, "ready_during_reset_busy6");
    expect_next(K_BUSY, 0, "midreset_busy");
    expect_next(K_PEND, 0, "midreset_pending");
    expect_next(K_STL, 0, "midreset_stall");
    expect_next(K_ERR, 0, "midreset_err");
    step();
    rst = 0; idle();
    step();

    for (int i = 0; i < 5 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      $display("FAIL drain pending=%0d expected=0", q.size());
      errors += q.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
